// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver with parity/framing/break flags and a one-word output register.
// rx_valid rises 2 clocks after the last stop sample; a frame completing while the word is still held is dropped (rx_overrun).
module uart_rx_frame #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int DIV = (CLK_FREQ + BAUD*OVERSAMPLING/2) / (BAUD*OVERSAMPLING);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLING);

  generate
    if (!(OVERSAMPLING == 8 || OVERSAMPLING == 16)) begin : gBadOversampling
      $error("uart_rx_frame: OVERSAMPLING must be 8 or 16");
    end
    if (DIV < 2) begin : gBadDiv
      $error("uart_rx_frame: clock too slow for BAUD*OVERSAMPLING");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
      $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : gBadParity
      $error("uart_rx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, COMMIT, WAITHI} stateT;

  stateT                state, nextState;
  logic                 rxdMeta, rxd_s;
  logic [TW-1:0]        tickCnt;
  logic                 tick;
  logic [OW-1:0]        ovCnt;
  logic [3:0]           bitCnt;
  logic                 startDet, sample, commit, load;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parBit, frameErr, anyOne, lastStop, parityErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxdMeta <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      rxdMeta <= rxd;
      rxd_s   <= rxdMeta;
    end
  end

  assign tick     = (tickCnt == TW'(DIV-1));
  assign startDet = (state == IDLE) && !rxd_s;

  // Tick phase is realigned to the detected start edge so sample points stay centred.
  always_ff @(posedge clk) begin
    if (rst || startDet || tick) tickCnt <= '0;
    else                         tickCnt <= tickCnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || startDet || sample) ovCnt <= '0;
    else if (tick)                 ovCnt <= ovCnt + OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                     bitCnt <= '0;
    else if (state != nextState) bitCnt <= '0;
    else if (sample)             bitCnt <= bitCnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    sample    = 1'b0;
    commit    = 1'b0;
    load      = 1'b0;
    rx_busy   = (state != IDLE);
    case (state)
      IDLE:   if (!rxd_s) nextState = START;
      START: begin
        sample = tick && (ovCnt == OW'(OVERSAMPLING/2 - 1));
        if (sample) nextState = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        sample = tick && (ovCnt == OW'(OVERSAMPLING - 1));
        if (sample && bitCnt == 4'(DATA_BITS - 1)) nextState = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        sample = tick && (ovCnt == OW'(OVERSAMPLING - 1));
        if (sample) nextState = STOP;
      end
      STOP: begin
        sample = tick && (ovCnt == OW'(OVERSAMPLING - 1));
        if (sample && bitCnt == 4'(STOP_BITS - 1)) nextState = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        load      = !rx_valid || rx_ready;
        nextState = lastStop ? IDLE : WAITHI;
      end
      WAITHI: if (rxd_s) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      parBit   <= 1'b0;
      frameErr <= 1'b0;
      anyOne   <= 1'b0;
      lastStop <= 1'b0;
    end else begin
      if (startDet) begin
        frameErr <= 1'b0;
        anyOne   <= 1'b0;
      end
      if (sample) begin
        case (state)
          DATA: begin
            shiftReg <= {rxd_s, shiftReg[DATA_BITS-1:1]};
            anyOne   <= anyOne | rxd_s;
          end
          PAR: begin
            parBit <= rxd_s;
            anyOne <= anyOne | rxd_s;
          end
          STOP: begin
            frameErr <= frameErr | !rxd_s;
            lastStop <= rxd_s;
            anyOne   <= anyOne | rxd_s;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    parityErr = 1'b0;
    if (PARITY == 1)      parityErr = !(^shiftReg ^ parBit);
    else if (PARITY == 2) parityErr = ^shiftReg ^ parBit;
  end

  // A consumer draining the held word on the COMMIT clock makes room for the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= commit && !load;
      if (load) begin
        rx_data       <= shiftReg;
        rx_parity_err <= parityErr;
        rx_frame_err  <= frameErr;
        rx_break      <= !anyOne;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised and directed frames for uart_rx_frame in a 7E2 configuration, scored against a frame-level model.
module tb_uart_rx_frame;

  localparam int CLK_FREQ   = 16;
  localparam int BAUD       = 1;
  localparam int OS         = 8;
  localparam int DB         = 7;
  localparam int PAR        = 2;
  localparam int SB         = 2;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD;
  localparam int DIVR       = (CLK_FREQ + BAUD*OS/2) / (BAUD*OS);
  localparam int FRAME_BITS = DB + ((PAR != 0) ? 1 : 0) + SB;
  localparam int COMMIT_OFS = (OS/2 + FRAME_BITS*OS) * DIVR;
  localparam int HALF_CLKS  = (OS/2) * DIVR;

  typedef struct packed {
    logic          perr;
    logic          ferr;
    logic          brk;
    logic [DB-1:0] data;
  } wordT;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy;

  wordT expQ[$];
  wordT gotW;
  int   checks, failures, ovCount;

  uart_rx_frame #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLING(OS),
    .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected word from the bits put on the line.
  function automatic wordT model(input logic [DB-1:0] d, input logic p, input logic s1, input logic s2);
    wordT w;
    int   ones;
    ones   = $countones(d) + (p ? 1 : 0);
    w.data = d;
    w.perr = (PAR == 2) ? (ones % 2 == 1) : (PAR == 1) ? (ones % 2 == 0) : 1'b0;
    w.ferr = !s1 || (SB == 2 && !s2);
    w.brk  = (d == '0) && !p && !s1 && !s2;
    return w;
  endfunction

  task automatic sendFrame(input logic [DB-1:0] d, input logic p, input logic s1, input logic s2);
    rxd = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      cyc(BIT_CLKS);
    end
    if (PAR != 0) begin
      rxd = p;
      cyc(BIT_CLKS);
    end
    rxd = s1;
    cyc(BIT_CLKS);
    if (SB == 2) begin
      rxd = s2;
      cyc(BIT_CLKS);
    end
    rxd = 1'b1;
  endtask

  task automatic sendExp(input logic [DB-1:0] d, input logic p, input logic s1, input logic s2);
    expQ.push_back(model(d, p, s1, s2));
    sendFrame(d, p, s1, s2);
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (expQ.size() == 0) begin
        chk("unexpected_word", 32'(expQ.size()), 32'd1);
      end else begin
        gotW = expQ.pop_front();
        chk("word", {rx_parity_err, rx_frame_err, rx_break, rx_data}, gotW);
      end
    end
    if (!rst && rx_overrun) ovCount++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] d, rd;
    logic          p, s1, s2;
    int            busyCnt, ovBase, n;

    checks = 0; failures = 0; ovCount = 0;
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
    cyc(4);
    chk("reset_outputs", {rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy, rx_data}, 32'd0);
    rst = 1'b0;
    cyc(10);

    // Parity good and bad on the same data.
    sendExp(7'h35, 1'b0, 1'b1, 1'b1);
    sendExp(7'h35, 1'b1, 1'b1, 1'b1);
    cyc(20);

    // Framing error without break.
    sendExp(7'h3C, 1'b0, 1'b0, 1'b0);
    cyc(20);

    // Line held low for three frame times gives exactly one break word.
    expQ.push_back(model('0, 1'b0, 1'b0, 1'b0));
    rxd = 1'b0;
    cyc(3 * (FRAME_BITS + 1) * BIT_CLKS);
    chk("break_one_word", 32'(expQ.size()), 32'd0);
    chk("break_waits_high", rx_busy, 1'b1);
    rxd = 1'b1;
    cyc(20);
    sendExp(7'h55, 1'b0, 1'b1, 1'b1);
    cyc(20);

    // Short glitch is a false start.
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (rx_busy) busyCnt++;
    end
    chk("glitch_went_busy", 32'(busyCnt > 0), 32'd1);
    chk("glitch_busy_short", 32'(busyCnt <= HALF_CLKS + 2), 32'd1);
    chk("glitch_back_idle", rx_busy, 1'b0);

    // Stall: second frame overruns, first word held.
    rx_ready = 1'b0;
    ovBase = ovCount;
    expQ.push_back(model(7'h11, 1'b0, 1'b1, 1'b1));
    sendFrame(7'h11, 1'b0, 1'b1, 1'b1);
    sendFrame(7'h22, 1'b0, 1'b1, 1'b1);
    cyc(20);
    chk("ovr_valid_held", rx_valid, 1'b1);
    chk("ovr_data_held", rx_data, 7'h11);
    chk("ovr_pulse_count", 32'(ovCount - ovBase), 32'd1);
    rx_ready = 1'b1;
    cyc(3);
    chk("ovr_valid_fall", rx_valid, 1'b0);
    chk("ovr_drained", 32'(expQ.size()), 32'd0);

    // Ready raised around the COMMIT clock of the second frame: no overrun.
    rx_ready = 1'b0;
    ovBase = ovCount;
    expQ.push_back(model(7'h11, 1'b0, 1'b1, 1'b1));
    expQ.push_back(model(7'h22, 1'b0, 1'b1, 1'b1));
    sendFrame(7'h11, 1'b0, 1'b1, 1'b1);
    cyc(10);
    fork
      sendFrame(7'h22, 1'b0, 1'b1, 1'b1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rx_busy && n < 200);
        chk("commit_busy_rise", rx_busy, 1'b1);
        cyc(COMMIT_OFS - 2);
        rx_ready = 1'b1;
        cyc(3);
        rx_ready = 1'b0;
      end
    join
    cyc(20);
    chk("commit_no_overrun", 32'(ovCount - ovBase), 32'd0);
    chk("commit_valid", rx_valid, 1'b1);
    chk("commit_data", rx_data, 7'h22);
    rx_ready = 1'b1;
    cyc(3);
    chk("commit_drained", 32'(expQ.size()), 32'd0);

    // Reset during data bit 3 discards the partial frame.
    rd = 7'h70;
    rxd = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rxd = rd[i];
      cyc(BIT_CLKS);
    end
    rxd = rd[3];
    cyc(BIT_CLKS / 2);
    chk("pre_reset_busy", rx_busy, 1'b1);
    rst = 1'b1;
    rxd = 1'b1;
    cyc(1);
    chk("reset_midframe_outputs", {rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy, rx_data}, 32'd0);
    rst = 1'b0;
    cyc(20);
    chk("after_reset_idle", rx_busy, 1'b0);
    sendExp(7'h5A, 1'b0, 1'b1, 1'b1);
    cyc(20);

    // Random frames, including back-to-back, bad parity, bad stops and breaks.
    for (int f = 0; f < 30; f++) begin
      d  = DB'($urandom_range(0, (1 << DB) - 1));
      p  = ^d;
      if ($urandom_range(0, 4) == 0) p = !p;
      s1 = ($urandom_range(0, 7) != 0);
      s2 = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        d = '0; p = 1'b0; s1 = 1'b0; s2 = 1'b0;
      end
      sendExp(d, p, s1, s2);
      cyc(s2 ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end

    cyc(100);
    chk("all_words_seen", 32'(expQ.size()), 32'd0);
    chk("total_overruns", 32'(ovCount), 32'd1);
    chk("final_idle", rx_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
